pconv_sched: RTL and testbench

- Layer controller for the pointwise-convolution array: 1x1 kernel, one input value broadcast to OUTPUT_CHANNEL multiplier cells.
- Loops over input channels. For each channel it:
  - fetches that channel's weight vector from the weight ROM;
  - streams INPUT_SIZE*INPUT_SIZE pixels from the feature buffer into the array;
  - counts returned results.
- Drives the accumulator-control flags and the output-buffer write address, and raises done after the last result of the last channel.
- Sits between the layer sequencer (start/done) and the pconv datapath plus its memories.

---
 rtl/pconv_pkg.sv | 17 +
 rtl/pconv_if.sv | 21 ++
 rtl/pconv_sched_vld_delay_line.sv | 16 +
 rtl/pconv_sched.sv | 92 +++++++++
 tb/tb_pconv_sched.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pconv_pkg.sv
// pconv_pkg: shared state encoding, default layer geometry and derived-constant helpers
package pconv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  localparam int DEF_INPUT_CHANNEL = 3;
  localparam int DEF_INPUT_SIZE = 6;
  localparam int PIX_N = DEF_INPUT_SIZE * DEF_INPUT_SIZE;
  localparam int CH_W = $clog2(DEF_INPUT_CHANNEL) + 1;
  function automatic int pix_n(int s);
    return s * s;
  endfunction
  function automatic int ch_w(int ic);
    return $clog2(ic) + 1;
  endfunction
  function automatic int wd_limit(int pipe_lat, int rd_lat);
    return pipe_lat + rd_lat + 8;
  endfunction
endpackage

// File: rtl/pconv_if.sv
// pconv_if: sequencer handshake plus datapath/memory control bus of the pointwise-conv scheduler
interface pconv_if #(
  parameter int AW = 16,
  parameter int CH_W = pconv_pkg::CH_W
);
  logic start, abort, busy, done, err;
  logic [CH_W-1:0] w_addr;
  logic w_rd_en, fm_rd_en, pconv_ce, pconv_input_vld, pconv_dout_vld;
  logic acc_first, acc_last, out_wr_en;
  logic [AW-1:0] fm_addr, out_addr;
  modport master(
    input start, abort, pconv_dout_vld,
    output busy, done, err, w_addr, w_rd_en, fm_addr, fm_rd_en, pconv_ce,
    output pconv_input_vld, acc_first, acc_last, out_wr_en, out_addr
  );
  modport slave(
    output start, abort, pconv_dout_vld,
    input busy, done, err, w_addr, w_rd_en, fm_addr, fm_rd_en, pconv_ce,
    input pconv_input_vld, acc_first, acc_last, out_wr_en, out_addr
  );
endinterface

// File: rtl/pconv_sched_vld_delay_line.sv
// vld_delay_line: DEPTH-stage shift register keeping {vld, first, last} aligned, with synchronous clear
module vld_delay_line #(
  parameter int DEPTH = 1,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  localparam int N = DEPTH * W;
  logic [N-1:0] sr;
  // shift one stage per cycle; clear flushes every stage at once
  always_ff @(posedge clk) sr <= clr ? '0 : N'({sr, d});
  assign q = sr[N-1 -: W];
endmodule

// File: rtl/pconv_sched.sv
// pconv_sched: per-layer controller looping input channels through weight load, pixel stream and drain
module pconv_sched import pconv_pkg::*; #(
  parameter int INPUT_CHANNEL = DEF_INPUT_CHANNEL,
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int RD_LAT = 1,
  parameter int PIPE_LAT = 3,
  parameter int AW = 16
) (
  input logic clk,
  input logic rst_n,
  pconv_if.master bus
);
  localparam int NPIX = pix_n(INPUT_SIZE);
  localparam int CW = ch_w(INPUT_CHANNEL);
  localparam int WD = wd_limit(PIPE_LAT, RD_LAT);
  localparam logic [CW-1:0] LAST = CW'(INPUT_CHANNEL - 1);
  localparam logic [AW-1:0] NPIX_A = AW'(NPIX);
  localparam logic [AW-1:0] PIX_END = AW'(NPIX - 1);

  if (longint'(INPUT_CHANNEL) * NPIX > (longint'(1) << AW)) begin : g_chk
    $error("pconv_sched: INPUT_CHANNEL*INPUT_SIZE^2 exceeds the AW address space");
  end

  state_t state, nxt;
  logic [CW-1:0] ch;
  logic [AW-1:0] pix, rcnt;
  logic [2:0] wcnt;
  logic [15:0] wd;
  logic cnt_en, ch_done, wd_hit, err_q, clr;
  logic [2:0] dl_q;

  assign cnt_en = state == STREAM || state == DRAIN;
  assign ch_done = cnt_en && bus.pconv_dout_vld && rcnt == PIX_END;
  assign wd_hit = state == DRAIN && !bus.pconv_dout_vld && wd == 16'(WD - 1);
  assign clr = !rst_n || bus.abort;

  // state register
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;

  // next state; abort overrides every transition
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? LOAD_W : IDLE;
      LOAD_W:  nxt = wcnt == 3'(RD_LAT - 1) ? STREAM : LOAD_W;
      STREAM:  nxt = pix == PIX_END ? DRAIN : STREAM;
      DRAIN:   nxt = wd_hit ? DONE : ch_done ? (ch == LAST ? DONE : LOAD_W) : DRAIN;
      default: nxt = IDLE;
    endcase
    if (bus.abort) nxt = IDLE;
  end

  // channel, pixel, result, wait and watchdog counters; held at zero while idle
  always_ff @(posedge clk) begin
    if (clr || state == IDLE) begin
      ch <= '0;
      pix <= '0;
      rcnt <= '0;
      wcnt <= '0;
      wd <= '0;
    end else begin
      ch <= state == DRAIN && ch_done && ch != LAST ? ch + 1'b1 : ch;
      wcnt <= state == LOAD_W ? wcnt + 1'b1 : '0;
      pix <= state != STREAM || pix == PIX_END ? '0 : pix + 1'b1;
      rcnt <= ch_done ? '0 : rcnt + AW'(cnt_en && bus.pconv_dout_vld);
      wd <= state == DRAIN && !bus.pconv_dout_vld ? wd + 1'b1 : '0;
    end
  end

  // sticky drain-timeout flag, cleared by reset or an accepted start
  always_ff @(posedge clk)
    err_q <= !rst_n || (state == IDLE && bus.start) ? 1'b0 : err_q || (wd_hit && !bus.abort);

  vld_delay_line #(.DEPTH(RD_LAT), .W(3)) u_dl (
    .clk(clk),
    .clr(clr),
    .d({bus.fm_rd_en, bus.fm_rd_en && ch == '0, bus.fm_rd_en && ch == LAST}),
    .q(dl_q)
  );

  assign {bus.pconv_input_vld, bus.acc_first, bus.acc_last} = dl_q;
  assign bus.busy = state == LOAD_W || cnt_en;
  assign bus.pconv_ce = bus.busy;
  assign bus.done = state == DONE;
  assign bus.err = err_q;
  assign bus.w_rd_en = state == LOAD_W && wcnt == '0;
  assign bus.w_addr = ch;
  assign bus.fm_rd_en = state == STREAM;
  assign bus.fm_addr = AW'(ch) * NPIX_A + pix;
  assign bus.out_wr_en = cnt_en && bus.pconv_dout_vld && ch == LAST;
  assign bus.out_addr = rcnt;
endmodule

// File: tb/tb_pconv_sched.sv
// tb_pconv_sched: directed self-checking bench for the pointwise-conv layer scheduler
module tb_pconv_sched;
  import pconv_pkg::*;
  logic clk = 0, rst_n = 0;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;

  pconv_if #(.AW(16), .CH_W(ch_w(3))) a();
  pconv_if #(.AW(16), .CH_W(ch_w(1))) b();

  pconv_sched #(.INPUT_CHANNEL(3), .INPUT_SIZE(6), .RD_LAT(1), .PIPE_LAT(3), .AW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );
  pconv_sched #(.INPUT_CHANNEL(1), .INPUT_SIZE(6), .RD_LAT(3), .PIPE_LAT(3), .AW(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  // datapath models: results appear 3 cycles after input_vld; A can stall after 20 results or inject spurious results
  logic [2:0] pa = '0, pb = '0;
  logic stall_en = 0, spur_a = 0;
  int a_res = 0;
  always @(posedge clk) begin
    pa <= {pa[1:0], a.pconv_input_vld};
    pb <= {pb[1:0], b.pconv_input_vld};
    a_res <= !stall_en ? 0 : a_res + int'(pa[2]);
  end
  assign a.pconv_dout_vld = (pa[2] && !(stall_en && a_res >= 20)) || spur_a;
  assign b.pconv_dout_vld = pb[2];

  task automatic test_reset();
    logic [44:0] va;
    logic [42:0] vb;
    a.start = 0; a.abort = 0; b.start = 0; b.abort = 0; rst_n = 0;
    repeat (3) @(negedge clk);
    va = {a.busy, a.done, a.err, a.w_rd_en, a.w_addr, a.fm_rd_en, a.fm_addr, a.pconv_ce,
          a.pconv_input_vld, a.acc_first, a.acc_last, a.out_wr_en, a.out_addr};
    vb = {b.busy, b.done, b.err, b.w_rd_en, b.w_addr, b.fm_rd_en, b.fm_addr, b.pconv_ce,
          b.pconv_input_vld, b.acc_first, b.acc_last, b.out_wr_en, b.out_addr};
    n_checks++; if (va !== '0) begin n_fail++; $display("FAIL reset_a: outputs %h expected 0", va); end
    n_checks++; if (vb !== '0) begin n_fail++; $display("FAIL reset_b: outputs %h expected 0", vb); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int wn = 0, fn = 0, iv = 0, on = 0, busy_bad = 0, flag_bad = 0, extra_done = 0;
    bit seen = 0;
    a.start = 1; @(negedge clk); a.start = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (a.w_rd_en) begin
        n_checks++; if (a.w_addr !== 3'(wn)) begin n_fail++; $display("FAIL basic_w_addr: got %0d expected %0d", a.w_addr, wn); end
        wn++;
      end
      if (a.fm_rd_en) begin
        n_checks++; if (a.fm_addr !== 16'(fn)) begin n_fail++; $display("FAIL basic_fm_addr: got %0d expected %0d", a.fm_addr, fn); end
        fn++;
      end
      if (a.pconv_input_vld) begin
        n_checks++;
        if ({a.acc_first, a.acc_last} !== {iv < 36, iv >= 72}) begin
          n_fail++; $display("FAIL basic_flags: vld %0d first/last %b%b expected %b%b", iv, a.acc_first, a.acc_last, iv < 36, iv >= 72);
        end
        iv++;
      end else if (a.acc_first || a.acc_last) flag_bad++;
      if (a.out_wr_en) begin
        n_checks++;
        if (a.out_addr !== 16'(on) || wn != 3) begin n_fail++; $display("FAIL basic_out_addr: got %0d (w pulses %0d) expected %0d (3)", a.out_addr, wn, on); end
        on++;
      end
      if (a.done) begin
        seen = 1;
        n_checks++; if (a.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b expected 0", a.busy); end
      end else if (a.busy !== 1'b1) busy_bad++;
      a.start = c == 20;
      if (!seen) @(negedge clk);
    end
    a.start = 0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL basic_timeout: done %b expected 1", seen); end
    n_checks++; if (wn != 3) begin n_fail++; $display("FAIL basic_w_count: got %0d expected 3", wn); end
    n_checks++; if (fn != 108) begin n_fail++; $display("FAIL basic_fm_count: got %0d expected 108", fn); end
    n_checks++; if (iv != 108) begin n_fail++; $display("FAIL basic_vld_count: got %0d expected 108", iv); end
    n_checks++; if (on != 36) begin n_fail++; $display("FAIL basic_wr_count: got %0d expected 36", on); end
    n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL basic_busy: %0d low cycles expected 0", busy_bad); end
    n_checks++; if (flag_bad != 0) begin n_fail++; $display("FAIL basic_stray_flags: got %0d expected 0", flag_bad); end
    n_checks++; if (a.err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", a.err); end
    repeat (5) begin @(negedge clk); if (a.done) extra_done++; end
    n_checks++; if (extra_done != 0) begin n_fail++; $display("FAIL basic_single_done: extra %0d expected 0", extra_done); end
  endtask

  task automatic test_spurious();
    spur_a = 1;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if ({a.out_wr_en, a.busy, a.pconv_ce, a.out_addr, a.fm_addr} !== '0) begin
        n_fail++; $display("FAIL spurious_idle: wr %b busy %b out_addr %0d fm_addr %0d expected all 0", a.out_wr_en, a.busy, a.out_addr, a.fm_addr);
      end
    end
    spur_a = 0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit hit = 0, seen = 0;
    int stray = 0, fn = 0;
    a.start = 1; @(negedge clk); a.start = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (a.fm_rd_en && a.fm_addr == 16'd46) hit = 1;
      else @(negedge clk);
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL abort_reach: fm_addr 46 seen %b expected 1", hit); end
    a.abort = 1; @(negedge clk); a.abort = 0;
    n_checks++;
    if ({a.busy, a.pconv_ce, a.pconv_input_vld, a.fm_rd_en, a.done} !== '0) begin
      n_fail++; $display("FAIL abort_next: busy/ce/vld/rd/done %b%b%b%b%b expected 00000", a.busy, a.pconv_ce, a.pconv_input_vld, a.fm_rd_en, a.done);
    end
    repeat (20) begin @(negedge clk); if (a.pconv_input_vld || a.done || a.busy) stray++; end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", stray); end
    a.start = 1; @(negedge clk); a.start = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (a.fm_rd_en) begin
        n_checks++; if (a.fm_addr !== 16'(fn)) begin n_fail++; $display("FAIL abort_rerun_addr: got %0d expected %0d", a.fm_addr, fn); end
        fn++;
      end
      if (a.done) seen = 1; else @(negedge clk);
    end
    n_checks++; if (!seen || fn != 108) begin n_fail++; $display("FAIL abort_rerun: done %b reads %0d expected 1 and 108", seen, fn); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int last_rd = -1, done_c = -1, fn = 0;
    bit seen = 0;
    logic err_at_done = 0;
    stall_en = 1;
    a.start = 1; @(negedge clk); a.start = 0;
    for (int c = 0; c < 300 && done_c < 0; c++) begin
      if (a.fm_rd_en) begin last_rd = c; fn++; end
      if (a.done) begin done_c = c; err_at_done = a.err; end
      else @(negedge clk);
    end
    n_checks++; if (done_c < 0) begin n_fail++; $display("FAIL stall_timeout: done seen %0d expected 1", 0); end
    n_checks++; if (done_c - last_rd != 13) begin n_fail++; $display("FAIL stall_gap: got %0d cycles expected 13", done_c - last_rd); end
    n_checks++; if (err_at_done !== 1'b1) begin n_fail++; $display("FAIL stall_err: got %b expected 1", err_at_done); end
    n_checks++; if (fn != 36) begin n_fail++; $display("FAIL stall_reads: got %0d expected 36", fn); end
    stall_en = 0;
    @(negedge clk);
    n_checks++; if (a.err !== 1'b1) begin n_fail++; $display("FAIL stall_sticky: got %b expected 1", a.err); end
    a.start = 1; @(negedge clk); a.start = 0;
    n_checks++; if (a.err !== 1'b0) begin n_fail++; $display("FAIL stall_err_clear: got %b expected 0", a.err); end
    for (int c = 0; c < 400 && !seen; c++) begin
      if (a.done) seen = 1; else @(negedge clk);
    end
    n_checks++; if (!seen || a.err !== 1'b0) begin n_fail++; $display("FAIL stall_rerun: done %b err %b expected 1 and 0", seen, a.err); end
    @(negedge clk);
  endtask

  task automatic test_single_channel();
    logic [2:0] hist;
    int iv = 0, on = 0, bad = 0, last_wr = -1, done_c = -1, lag_bad = 0;
    hist = '0;
    b.start = 1; @(negedge clk); b.start = 0;
    for (int c = 0; c < 300 && done_c < 0; c++) begin
      if (b.pconv_input_vld !== hist[2]) lag_bad++;
      hist = {hist[1:0], b.fm_rd_en};
      if (b.pconv_input_vld) begin iv++; if (!(b.acc_first && b.acc_last)) bad++; end
      if (b.out_wr_en) begin
        n_checks++; if (b.out_addr !== 16'(on)) begin n_fail++; $display("FAIL single_out_addr: got %0d expected %0d", b.out_addr, on); end
        on++; last_wr = c;
      end
      if (b.done) done_c = c; else @(negedge clk);
    end
    n_checks++; if (done_c < 0) begin n_fail++; $display("FAIL single_timeout: done seen %0d expected 1", 0); end
    n_checks++; if (lag_bad != 0) begin n_fail++; $display("FAIL single_lag: got %0d misaligned cycles expected 0", lag_bad); end
    n_checks++; if (iv != PIX_N) begin n_fail++; $display("FAIL single_vld_count: got %0d expected %0d", iv, PIX_N); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL single_flags: got %0d bad cycles expected 0", bad); end
    n_checks++; if (on != 36) begin n_fail++; $display("FAIL single_wr_count: got %0d expected 36", on); end
    n_checks++; if (done_c != last_wr + 1) begin n_fail++; $display("FAIL single_done_time: got %0d expected %0d", done_c, last_wr + 1); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spurious();
    test_abort();
    test_stall();
    test_single_channel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
